// File: rtl/prog_loader.sv
// Streams a program of load_len bytes into memory, verifies a trailing checksum byte,
// and releases the execution unit only after a verified load.
module prog_loader #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   load_len,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_BITS:0]   MAX_LEN  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   LEN_ZERO = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0]   LEN_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

  state_t               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS:0]   cnt_q;
  logic [ADDR_BITS:0]   len_q;
  logic [DATA_BITS-1:0] csum_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 cpu_reset_q;
  logic                 mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_q;

  logic                 len_ok_s;
  logic                 xfer_s;
  logic [ADDR_BITS:0]   cnt_d;
  logic [DATA_BITS-1:0] csum_d;

  // Status bits {in_ready, busy, done, error, cpu_reset} registered alongside the state
  function automatic logic [4:0] status_f(input state_t s);
    case (s)
      LOAD, CHECK: status_f = 5'b11001;
      DONE:        status_f = 5'b00100;
      ERR:         status_f = 5'b00011;
      default:     status_f = 5'b00001;
    endcase
  endfunction

  // Length legality, handshake and running count/checksum increments
  always_comb begin
    len_ok_s = (load_len != LEN_ZERO) && (load_len[0] == 1'b0) && (load_len <= MAX_LEN);
    xfer_s   = in_valid && in_ready_q;
    cnt_d    = cnt_q + LEN_ONE;
    csum_d   = csum_q + in_data;
  end

  // Session FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= ADDR_ZERO;
      cnt_q       <= LEN_ZERO;
      len_q       <= LEN_ZERO;
      csum_q      <= DATA_ZERO;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_ZERO;
      mem_wdata_q <= DATA_ZERO;
      {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(IDLE);
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            if (len_ok_s) begin
              state_q <= LOAD;
              addr_q  <= ADDR_ZERO;
              cnt_q   <= LEN_ZERO;
              csum_q  <= DATA_ZERO;
              len_q   <= load_len;
              {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(LOAD);
            end else begin
              state_q <= ERR;
              {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(ERR);
            end
          end else begin
            state_q <= state_q;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= in_data;
            // A full 2^ADDR_BITS load wraps the counter back to 0 here
            addr_q      <= addr_q + ADDR_ONE;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            if (cnt_d == len_q) begin
              state_q <= CHECK;
              {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(CHECK);
            end else begin
              state_q <= LOAD;
            end
          end else begin
            state_q <= LOAD;
          end
        end
        CHECK: begin
          if (xfer_s) begin
            if (csum_d == DATA_ZERO) begin
              state_q <= DONE;
              {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(DONE);
            end else begin
              state_q <= ERR;
              {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(ERR);
            end
          end else begin
            state_q <= CHECK;
          end
        end
        default: begin
          state_q <= IDLE;
          {in_ready_q, busy_q, done_q, error_q, cpu_reset_q} <= status_f(IDLE);
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_reset = cpu_reset_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a session-level reference model checked every cycle, directed
// scenarios with literal expectations, and randomized sessions.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int DB = 8;
  localparam int AB = 8;
  localparam int MEMSZ = 1 << AB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AB:0]   load_len = '0;
  logic [DB-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, cpu_reset, busy, done, error;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata;

  always #5 clk = ~clk;

  prog_loader #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session phase, byte count and running sum
  typedef enum {M_IDLE, M_LOAD, M_CHECK, M_DONE, M_ERR} mphase_t;
  mphase_t m_ph = M_IDLE;
  int m_len = 0, m_cnt = 0, m_sum = 0, m_addr = 0, m_wdata = 0;
  bit m_we = 1'b0;
  bit armed = 1'b0;
  int dut_writes = 0;
  int mem_img [MEMSZ];

  always @(posedge clk) begin
    m_we = 1'b0;
    if (!reset) begin
      m_ph = M_IDLE; m_cnt = 0; m_sum = 0; m_addr = 0; m_wdata = 0; armed = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE, M_DONE, M_ERR:
          if (start) begin
            if (load_len == 0 || load_len % 2 == 1 || int'(load_len) > MEMSZ) m_ph = M_ERR;
            else begin
              m_len = int'(load_len); m_cnt = 0; m_sum = 0; m_ph = M_LOAD;
            end
          end
        M_LOAD:
          if (in_valid) begin
            m_we = 1'b1; m_addr = m_cnt % MEMSZ; m_wdata = int'(in_data);
            m_sum = (m_sum + int'(in_data)) % 256;
            m_cnt++;
            if (m_cnt == m_len) m_ph = M_CHECK;
          end
        M_CHECK:
          if (in_valid) m_ph = ((m_sum + int'(in_data)) % 256 == 0) ? M_DONE : M_ERR;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", in_ready, (m_ph == M_LOAD || m_ph == M_CHECK));
      chk("busy", busy, (m_ph == M_LOAD || m_ph == M_CHECK));
      chk("done", done, (m_ph == M_DONE));
      chk("error", error, (m_ph == M_ERR));
      chk("cpu_reset", cpu_reset, (m_ph != M_DONE));
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      if (mem_we === 1'b1) begin
        dut_writes++;
        mem_img[mem_addr] = int'(mem_wdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; load_len = len[AB:0]; tick(); start = 1'b0;
  endtask

  task automatic send(input int b);
    start = 1'b0; in_valid = 1'b1; in_data = b[DB-1:0]; tick(); in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit poke_start);
    for (int i = 0; i < n; i++) begin
      in_data = DB'($urandom);
      start = poke_start ? 1'($urandom) : 1'b0;
      load_len = (AB+1)'($urandom_range(0, 40));
      tick();
    end
    start = 1'b0;
  endtask

  logic [7:0] t34 [10] = '{8'h00, 8'h00, 8'h17, 8'hFE, 8'h11, 8'h7F, 8'h90, 8'h00, 8'h0A, 8'hAA};
  int w0, sum, b0, b1;

  initial begin
    repeat (3) tick();
    chk("rst_cpu_reset", cpu_reset, 1); chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Known-good stream: checksum byte 0x17
    w0 = dut_writes; do_start(10);
    for (int i = 0; i < 10; i++) send(int'(t34[i]));
    chk("t34_model_sum", m_sum, 32'hE9);
    send(8'h17);
    chk("t34_writes", dut_writes - w0, 10); chk("t34_done", done, 1);
    chk("t34_cpu_reset", cpu_reset, 0);
    chk("t34_mem2", mem_img[2], 8'h17); chk("t34_mem9", mem_img[9], 8'hAA);

    // Same stream, checksum off by one
    w0 = dut_writes; do_start(10);
    for (int i = 0; i < 10; i++) send(int'(t34[i]));
    send(8'h18);
    chk("t35_writes", dut_writes - w0, 10); chk("t35_error", error, 1);
    chk("t35_done", done, 0); chk("t35_cpu_reset", cpu_reset, 1);

    // Illegal lengths
    w0 = dut_writes; do_start(3); chk("t36_len3_err", error, 1);
    idle(2, 1'b0);
    do_start(0); chk("t36_len0_err", error, 1);
    do_start(258); chk("t36_len258_err", error, 1);
    idle(2, 1'b0);
    chk("t36_writes", dut_writes - w0, 0);

    // Stalls inside LOAD
    w0 = dut_writes; b0 = 8'h3C; b1 = 8'h5A; do_start(2);
    send(b0); idle(2, 1'b1); send(b1);
    chk("t37_writes", dut_writes - w0, 2);
    chk("t37_mem0", mem_img[0], 8'h3C); chk("t37_mem1", mem_img[1], 8'h5A);
    send((512 - b0 - b1) % 256); chk("t37_done", done, 1);

    // Reset mid-session, with start and a transfer pending in the same cycle
    w0 = dut_writes; do_start(6);
    for (int i = 0; i < 3; i++) send(8'h40 + i);
    reset = 1'b0; start = 1'b1; load_len = 9'd4; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    chk("t38_busy", busy, 0); chk("t38_cpu_reset", cpu_reset, 1);
    chk("t38_in_ready", in_ready, 0);
    idle(2, 1'b0);
    chk("t38_writes", dut_writes - w0, 3);
    do_start(2); send(8'h99); chk("t38_restart_addr0", mem_img[0], 8'h99);
    send(8'h01); send(8'h66); chk("t38_done", done, 1);

    // Full-size load wraps the counter
    w0 = dut_writes; sum = 0; do_start(MEMSZ);
    for (int i = 0; i < MEMSZ; i++) begin
      b0 = $urandom_range(0, 255); sum += b0; send(b0);
    end
    chk("t39_in_check", in_ready, 1);
    chk("t39_counter0", dut.addr_q, 0);
    send((256 - sum % 256) % 256);
    chk("t39_writes", dut_writes - w0, MEMSZ); chk("t39_done", done, 1);

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int len;
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 1) ? 2 * $urandom_range(0, 10) + 1 : MEMSZ + 2 * $urandom_range(1, 100);
      else len = 2 * $urandom_range(1, 20);
      sum = 0; w0 = dut_writes;
      do_start(len);
      if (len % 2 == 0 && len <= MEMSZ) begin
        for (int i = 0; i < len; i++) begin
          idle($urandom_range(0, 2), 1'b1);
          b0 = $urandom_range(0, 255); sum += b0; send(b0);
        end
        idle($urandom_range(0, 2), 1'b1);
        b1 = (256 - sum % 256) % 256;
        if ($urandom_range(0, 2) == 0) b1 = (b1 + $urandom_range(1, 255)) % 256;
        send(b1);
        chk("rnd_writes", dut_writes - w0, len);
      end
      idle($urandom_range(1, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
